// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with registered reads, pending-write scoreboard; optional REGFILE_BYPASS_EN
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ena,
    input  logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dataa,
    input  logic              enb,
    input  logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] datab,
    input  logic              enc,
    input  logic [ADDR_W-1:0] addrc,
    input  logic [DATA_W-1:0] datac,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic [ADDR_W:0]   pending
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   count_next;

    logic              zero_a, zero_b, zero_c, zero_i;
    logic              byp_a, byp_b;
    logic [DATA_W-1:0] rd_a, rd_b;

    // Address decode for the hardwired zero register and same-edge bypass hits
    always_comb begin
        zero_a = (ZERO_REG != 0) && (addra == '0);
        zero_b = (ZERO_REG != 0) && (addrb == '0);
        zero_c = (ZERO_REG != 0) && (addrc == '0);
        zero_i = (ZERO_REG != 0) && (issue_addr == '0);
`ifdef REGFILE_BYPASS_EN
        byp_a = enc && (addrc == addra);
        byp_b = enc && (addrc == addrb);
`else
        byp_a = 1'b0;
        byp_b = 1'b0;
`endif
    end

    // Read-port data selection: zero register first, then forwarded write data, then storage
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (!zero_a) rd_a = byp_a ? datac : mem[addra];
        if (!zero_b) rd_b = byp_b ? datac : mem[addrb];
    end

    // Scoreboard next state: writeback clears, issue sets, set wins on a collision
    always_comb begin
        busy_next = busy;
        if (enc) busy_next[addrc] = 1'b0;
        if (issue_en && !zero_i) busy_next[issue_addr] = 1'b1;
    end

    // Population count of the post-update busy vector feeds the registered pending count
    always_comb begin
        count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + {{ADDR_W{1'b0}}, busy_next[i]};
        end
    end

    // Hazards look only at live inputs and busy state, never at the read data registers
    always_comb begin
        hazard_a = ena && busy[addra] && !byp_a && !zero_a;
        hazard_b = enb && busy[addrb] && !byp_b && !zero_b;
    end

    // Register storage: writes to the zero register are dropped
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (enc && !zero_c) begin
            mem[addrc] <= datac;
        end
    end

    // Registered read ports hold their value while disabled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dataa <= '0;
            datab <= '0;
        end else begin
            if (ena) dataa <= rd_a;
            if (enb) datab <= rd_b;
        end
    end

    // Busy bits and the pending count move together so pending always matches busy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy    <= '0;
            pending <= '0;
        end else begin
            busy    <= busy_next;
            pending <= count_next;
        end
    end

endmodule
